// File: rtl/dstack_seq.sv
// ============================================================================
//  Module      : dstack_seq
//  Description : Operation sequencer for a data stack.
//                Decodes stack ops into movement/next_top/rotate controls and
//                tracks faults. Optional DROPN (multi-cycle drop) is built
//                only when DSTACK_SEQ_DROPN_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dstack_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    input  logic [5:0]       op_addr,
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] second,
    input  logic [WIDTH-1:0] third,
    input  logic [WIDTH-1:0] rot_val,
    input  logic             overflow,
    input  logic             underflow,
    output logic [1:0]       movement,
    output logic [WIDTH-1:0] next_top,
    output logic             rotate,
    output logic [5:0]       rot_addr,
    output logic             fault,
    output logic [1:0]       fault_code,
    input  logic             fault_clear
);

    localparam logic [2:0] C_OP_NOP   = 3'b000;
    localparam logic [2:0] C_OP_PUSH  = 3'b001;
    localparam logic [2:0] C_OP_DROP  = 3'b010;
    localparam logic [2:0] C_OP_DROP2 = 3'b011;
    localparam logic [2:0] C_OP_ROT   = 3'b100;
    localparam logic [2:0] C_OP_COPY  = 3'b101;
    localparam logic [2:0] C_OP_DROPN = 3'b110;
    localparam logic [2:0] C_OP_ADD   = 3'b111;

    localparam logic [1:0] C_MV_HOLD  = 2'b00;
    localparam logic [1:0] C_MV_PUSH  = 2'b01;
    localparam logic [1:0] C_MV_POP   = 2'b10;
    localparam logic [1:0] C_MV_POP2  = 2'b11;

    localparam logic [1:0] C_FC_NONE  = 2'b00;
    localparam logic [1:0] C_FC_OVF   = 2'b01;
    localparam logic [1:0] C_FC_UNF   = 2'b10;
    localparam logic [1:0] C_FC_ILL   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef DSTACK_SEQ_DROPN_EN
        S_DROPN = 2'd1,
`endif
        S_FAULT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       fault_q, fault_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic       w_issue;
    logic       w_illegal;

`ifdef DSTACK_SEQ_DROPN_EN
    logic [6:0] remaining_q, remaining_d;
    logic [6:0] w_dropn_cnt;
    assign w_dropn_cnt = op_imm[6:0];
`endif

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        op_ready     = 1'b0;
        movement     = C_MV_HOLD;
        next_top     = top;
        rotate       = 1'b0;
        rot_addr     = 6'd0;
        w_issue      = 1'b0;
        w_illegal    = 1'b0;
`ifdef DSTACK_SEQ_DROPN_EN
        remaining_d  = remaining_q;
`endif

        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    op_ready = 1'b1;
                    if (op_valid) begin
                        w_issue = 1'b1;
                        case (op_code)
                            C_OP_NOP: ;
                            C_OP_PUSH: begin
                                movement = C_MV_PUSH;
                                next_top = op_imm;
                            end
                            C_OP_DROP: begin
                                movement = C_MV_POP;
                                next_top = second;
                            end
                            C_OP_DROP2: begin
                                movement = C_MV_POP2;
                                next_top = third;
                            end
                            C_OP_ROT: begin
                                rotate   = 1'b1;
                                rot_addr = op_addr;
                                next_top = rot_val;
                            end
                            C_OP_COPY: begin
                                movement = C_MV_PUSH;
                                rot_addr = op_addr;
                                next_top = rot_val;
                            end
                            C_OP_DROPN: begin
`ifdef DSTACK_SEQ_DROPN_EN
                                if (w_dropn_cnt == 7'd1) begin
                                    movement = C_MV_POP;
                                    next_top = second;
                                end else if (w_dropn_cnt >= 7'd2) begin
                                    movement    = C_MV_POP2;
                                    next_top    = third;
                                    remaining_d = w_dropn_cnt - 7'd2;
                                    if (remaining_d != 7'd0) state_d = S_DROPN;
                                end
`else
                                w_illegal = 1'b1;
`endif
                            end
                            C_OP_ADD: begin
                                movement = C_MV_POP;
                                next_top = top + second;
                            end
                            default: ;
                        endcase
                    end
                end
`ifdef DSTACK_SEQ_DROPN_EN
                S_DROPN: begin
                    w_issue = 1'b1;
                    if (remaining_q >= 7'd2) begin
                        movement    = C_MV_POP2;
                        next_top    = third;
                        remaining_d = remaining_q - 7'd2;
                    end else begin
                        movement    = C_MV_POP;
                        next_top    = second;
                        remaining_d = 7'd0;
                    end
                    if (remaining_d == 7'd0) state_d = S_IDLE;
                end
`endif
                S_FAULT: begin
                    if (fault_clear) begin
                        state_d      = S_IDLE;
                        fault_d      = 1'b0;
                        fault_code_d = C_FC_NONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A fault in any issuing cycle wins over everything, aborting DROPN.
            if (w_issue && (overflow || underflow || w_illegal)) begin
                state_d      = S_FAULT;
                fault_d      = 1'b1;
                fault_code_d = overflow  ? C_FC_OVF :
                               underflow ? C_FC_UNF : C_FC_ILL;
`ifdef DSTACK_SEQ_DROPN_EN
                remaining_d  = 7'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fault_q      <= 1'b0;
            fault_code_q <= C_FC_NONE;
`ifdef DSTACK_SEQ_DROPN_EN
            remaining_q  <= 7'd0;
`endif
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
`ifdef DSTACK_SEQ_DROPN_EN
            remaining_q  <= remaining_d;
`endif
        end
    end

    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

`default_nettype wire

// File: tb/tb_dstack_seq.sv
// ============================================================================
//  Module      : tb_dstack_seq
//  Description : Scoreboard bench for dstack_seq driven by a queue-based stack
//                model; DROPN expectations follow DSTACK_SEQ_DROPN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dstack_seq;

    localparam int W   = 32;
    localparam int CAP = 8;

    logic         clk;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   op_code;
    logic [W-1:0] op_imm;
    logic [5:0]   op_addr;
    logic [W-1:0] top, second, third, rot_val;
    logic         overflow, underflow;
    logic [1:0]   movement;
    logic [W-1:0] next_top;
    logic         rotate;
    logic [5:0]   rot_addr;
    logic         fault;
    logic [1:0]   fault_code;
    logic         fault_clear;

    dstack_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_imm     (op_imm),
        .op_addr    (op_addr),
        .top        (top),
        .second     (second),
        .third      (third),
        .rot_val    (rot_val),
        .overflow   (overflow),
        .underflow  (underflow),
        .movement   (movement),
        .next_top   (next_top),
        .rotate     (rotate),
        .rot_addr   (rot_addr),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_clear(fault_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         ready;
        logic [1:0]   mv;
        logic [W-1:0] nt;
        logic         rot;
        logic [5:0]   ra;
        logic         flt;
        logic [1:0]   fc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_exp, mon_act;
    int           checks = 0;
    int           errors = 0;

    // Reference model: a plain value stack plus sequencer bookkeeping.
    logic [W-1:0] stk[$];
    int           pending = 0;
    bit           m_fault = 0;
    logic [1:0]   m_code  = 2'b00;

    function automatic logic [W-1:0] sv(input int i);
        return (i < stk.size()) ? stk[i] : '0;
    endfunction

    task automatic step(input logic rst, input logic vld, input logic [2:0] code,
                        input logic [W-1:0] imm, input logic [5:0] addr, input logic clr);
        exp_t e;
        bit   issue, illegal, ov, uf;
        int   n;
        @(posedge clk);
        #1;
        reset       = rst;
        op_valid    = vld;
        op_code     = code;
        op_imm      = imm;
        op_addr     = addr;
        fault_clear = clr;
        top         = sv(0);
        second      = sv(1);
        third       = sv(2);
        rot_val     = sv(int'(addr));
        e.ready = 1'b0; e.mv = 2'b00; e.nt = sv(0); e.rot = 1'b0; e.ra = 6'd0;
        e.flt = m_fault; e.fc = m_code;
        issue = 0; illegal = 0;
        if (rst) begin
            pending = 0; m_fault = 0; m_code = 2'b00;
        end else if (m_fault) begin
            if (clr) begin m_fault = 0; m_code = 2'b00; end
        end else if (pending > 0) begin
            issue = 1;
            if (pending >= 2) begin e.mv = 2'b11; e.nt = sv(2); pending -= 2; end
            else begin e.mv = 2'b10; e.nt = sv(1); pending -= 1; end
        end else begin
            e.ready = 1'b1;
            if (vld) begin
                issue = 1;
                case (code)
                    3'd1: begin e.mv = 2'b01; e.nt = imm; end
                    3'd2: begin e.mv = 2'b10; e.nt = sv(1); end
                    3'd3: begin e.mv = 2'b11; e.nt = sv(2); end
                    3'd4: begin e.rot = 1'b1; e.ra = addr; e.nt = sv(int'(addr)); end
                    3'd5: begin e.mv = 2'b01; e.ra = addr; e.nt = sv(int'(addr)); end
                    3'd6: begin
`ifdef DSTACK_SEQ_DROPN_EN
                        n = int'(imm[6:0]);
                        if (n == 1) begin e.mv = 2'b10; e.nt = sv(1); end
                        else if (n >= 2) begin e.mv = 2'b11; e.nt = sv(2); pending = n - 2; end
`else
                        n = 0;
                        illegal = 1;
`endif
                    end
                    3'd7: begin e.mv = 2'b10; e.nt = sv(0) + sv(1); end
                    default: ;
                endcase
            end
        end
        ov = (e.mv == 2'b01) && (stk.size() >= CAP);
        uf = ((e.mv == 2'b10) && (stk.size() < 1)) || ((e.mv == 2'b11) && (stk.size() < 2));
        overflow  = ov;
        underflow = uf;
        if (issue && (ov || uf || illegal)) begin
            m_fault = 1;
            m_code  = ov ? 2'b01 : (uf ? 2'b10 : 2'b11);
            pending = 0;
        end else begin
            case (e.mv)
                2'b01: stk.push_front(e.nt);
                2'b10: void'(stk.pop_front());
                2'b11: begin void'(stk.pop_front()); void'(stk.pop_front()); end
                default: ;
            endcase
            if (e.rot && (int'(addr) < stk.size())) begin
                stk.delete(int'(addr));
                stk.push_front(e.nt);
            end
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = '{op_ready, movement, next_top, rotate, rot_addr, fault, fault_code};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL outputs t=%0t got rdy=%b mv=%b nt=%h rot=%b ra=%0d flt=%b fc=%b exp rdy=%b mv=%b nt=%h rot=%b ra=%0d flt=%b fc=%b",
                         $time, mon_act.ready, mon_act.mv, mon_act.nt, mon_act.rot, mon_act.ra,
                         mon_act.flt, mon_act.fc, mon_exp.ready, mon_exp.mv, mon_exp.nt,
                         mon_exp.rot, mon_exp.ra, mon_exp.flt, mon_exp.fc);
            end
        end
    end

    task automatic nop(input logic clr);
        step(1'b0, 1'b0, 3'd0, '0, 6'd0, clr);
    endtask

    task automatic op(input logic [2:0] code, input logic [W-1:0] imm, input logic [5:0] addr);
        step(1'b0, 1'b1, code, imm, addr, 1'b0);
    endtask

    initial begin
        logic [2:0]   rc;
        logic [W-1:0] ri;
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_imm = '0; op_addr = 6'd0;
        top = '0; second = '0; third = '0; rot_val = '0;
        overflow = 1'b0; underflow = 1'b0; fault_clear = 1'b0;
        repeat (2) @(posedge clk);

        step(1'b1, 1'b1, 3'd1, 32'h1, 6'd0, 1'b0);
        nop(1'b0);
        op(3'd1, 32'h5, 6'd0);
        op(3'd1, 32'h7, 6'd0);
        op(3'd7, 32'h0, 6'd0);

        op(3'd1, 32'hAA, 6'd0);
        for (int i = 3; i >= 1; i--) op(3'd1, W'(i), 6'd0);
        op(3'd4, 32'h0, 6'd3);
        op(3'd5, 32'h0, 6'd2);
        op(3'd6, 32'd5, 6'd0);
        nop(1'b0); nop(1'b0);

        op(3'd6, 32'd127, 6'd0);
        repeat (4) nop(1'b0);
        op(3'd2, 32'h0, 6'd0);
        repeat (2) op(3'd1, 32'h9, 6'd0);
        nop(1'b1);
        nop(1'b0);

        for (int i = 0; i < 6; i++) op(3'd1, W'(i + 16), 6'd0);
        op(3'd6, 32'd8, 6'd0);
        step(1'b1, 1'b0, 3'd0, '0, 6'd0, 1'b0);
        repeat (3) nop(1'b0);
        op(3'd6, 32'd0, 6'd0);
        op(3'd6, 32'd1, 6'd0);
        nop(1'b0);
        nop(1'b1);

        for (int i = 0; i < 1500; i++) begin
            rc = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
            ri = $urandom();
            if (rc == 3'd6) ri = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 127))
                                                             : W'($urandom_range(0, 9));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), rc, ri,
                 6'($urandom_range(0, 9)), ($urandom_range(0, 3) == 0));
        end

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
